// File: rtl/evaluar_jugada.sv
// rtl/evaluar_jugada.sv - post-move referee: scans eight winning lines, reports win/draw, tracks turn and move count
module evaluar_jugada (
    input  logic        clock,
    input  logic        reset,
    input  logic        V,
    input  logic [17:0] board,
    input  logic        new_game,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw,
    output logic        game_over,
    output logic        playerID,
    output logic [3:0]  moves,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

    state_t      state, state_nx;
    logic [17:0] snap;
    logic [2:0]  idx;
    logic [3:0]  ka, kb, kc;
    logic [1:0]  box_a, box_b, box_c;
    logic        line_hit;

    // Zero-based box indices of the three boxes on line idx
    always_comb begin
        ka = 4'd0;
        kb = 4'd1;
        kc = 4'd2;
        case (idx)
            3'd0: begin ka = 4'd0; kb = 4'd1; kc = 4'd2; end
            3'd1: begin ka = 4'd3; kb = 4'd4; kc = 4'd5; end
            3'd2: begin ka = 4'd6; kb = 4'd7; kc = 4'd8; end
            3'd3: begin ka = 4'd0; kb = 4'd3; kc = 4'd6; end
            3'd4: begin ka = 4'd1; kb = 4'd4; kc = 4'd7; end
            3'd5: begin ka = 4'd2; kb = 4'd5; kc = 4'd8; end
            3'd6: begin ka = 4'd0; kb = 4'd4; kc = 4'd8; end
            default: begin ka = 4'd2; kb = 4'd4; kc = 4'd6; end
        endcase
    end

    assign box_a    = snap[{ka, 1'b0} +: 2];
    assign box_b    = snap[{kb, 1'b0} +: 2];
    assign box_c    = snap[{kc, 1'b0} +: 2];
    assign line_hit = (box_a == box_b) && (box_b == box_c) &&
                      ((box_a == 2'b01) || (box_a == 2'b10));

    assign busy = (state == SCAN);
    assign done = (state == REPORT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (new_game) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (V) state_nx = SCAN;
                SCAN:    if (line_hit || (idx == 3'd7)) state_nx = REPORT;
                REPORT:  state_nx = ((winner != 2'b00) || draw) ? OVER : IDLE;
                default: state_nx = OVER;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap      <= 18'd0;
            idx       <= 3'd0;
            winner    <= 2'b00;
            win_line  <= 3'd0;
            draw      <= 1'b0;
            game_over <= 1'b0;
            playerID  <= 1'b0;
            moves     <= 4'd0;
            overrun   <= 1'b0;
        end else if (new_game) begin
            idx       <= 3'd0;
            winner    <= 2'b00;
            win_line  <= 3'd0;
            draw      <= 1'b0;
            game_over <= 1'b0;
            playerID  <= 1'b0;
            moves     <= 4'd0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (V) begin
                        snap     <= board;
                        moves    <= (moves == 4'd9) ? 4'd9 : moves + 4'd1;
                        idx      <= 3'd0;
                        winner   <= 2'b00;
                        win_line <= 3'd0;
                        draw     <= 1'b0;
                    end
                end
                SCAN: begin
                    if (V) overrun <= 1'b1;
                    if (line_hit) begin
                        winner   <= box_a;
                        win_line <= idx;
                    end else if (idx == 3'd7) begin
                        draw <= (moves == 4'd9);
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                REPORT: begin
                    if (V) overrun <= 1'b1;
                    if ((winner != 2'b00) || draw) begin
                        game_over <= 1'b1;
                    end else begin
                        playerID <= ~playerID;
                    end
                end
                default: begin
                    if (V) overrun <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evaluar_jugada.sv
// tb/tb_evaluar_jugada.sv - directed self-checking bench for evaluar_jugada
module tb_evaluar_jugada;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        V = 1'b0;
    logic [17:0] board = 18'd0;
    logic        new_game = 1'b0;
    logic        busy, done, draw, game_over, playerID, overrun;
    logic [1:0]  winner;
    logic [2:0]  win_line;
    logic [3:0]  moves;

    int total = 0;
    int bad = 0;

    evaluar_jugada dut (
        .clock(clock), .reset(reset), .V(V), .board(board), .new_game(new_game),
        .busy(busy), .done(done), .winner(winner), .win_line(win_line), .draw(draw),
        .game_over(game_over), .playerID(playerID), .moves(moves), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Launch a move at the next negedge; lat = edges after E0 until done is seen
    task automatic move(input logic [17:0] b, output int lat);
        @(negedge clock);
        board = b;
        V = 1'b1;
        @(posedge clock);
        @(negedge clock);
        V = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic start_new_game;
        @(negedge clock);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    logic [1:0]  full_codes [9] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [17:0] full_board;
    int lat, done_cnt, first_done;

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_moves", moves, 0);
        chk("rst_player", playerID, 0);
        reset = 1'b1;

        // Empty board: full scan, no result
        move(18'd0, lat);
        chk("t1_lat", lat, 8);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_winner", winner, 0);
        chk("t1_draw", draw, 0);
        chk("t1_moves", moves, 1);
        tick();
        chk("t1_player", playerID, 1);
        chk("t1_over", game_over, 0);

        // Boxes 1,2,3 = 01: win on line 0
        move(18'h00015, lat);
        chk("t2_lat", lat, 1);
        chk("t2_winner", winner, 2'b01);
        chk("t2_line", win_line, 0);
        tick();
        chk("t2_over", game_over, 1);
        chk("t2_player", playerID, 1);
        chk("t2_moves", moves, 2);

        // Boxes 3,5,7 = 10: win on the last line, then V ignored
        start_new_game();
        chk("t3_clr_moves", moves, 0);
        chk("t3_clr_over", game_over, 0);
        move(18'h02220, lat);
        chk("t3_lat", lat, 8);
        chk("t3_winner", winner, 2'b10);
        chk("t3_line", win_line, 7);
        tick();
        board = 18'd0;
        V = 1'b1;
        tick();
        V = 1'b0;
        tick();
        chk("t3_overrun", overrun, 1);
        chk("t3_moves", moves, 1);
        chk("t3_winner_hold", winner, 2'b10);
        chk("t3_busy", busy, 0);

        // Nine moves on a full no-win board: draw on the ninth
        start_new_game();
        full_board = 18'd0;
        for (int k = 0; k < 9; k++) full_board[2*k +: 2] = full_codes[k];
        for (int m = 1; m <= 9; m++) begin
            move(full_board, lat);
            if (m < 9) chk("t4_draw_early", draw, 0);
        end
        chk("t4_lat", lat, 8);
        chk("t4_draw", draw, 1);
        chk("t4_winner", winner, 0);
        chk("t4_moves", moves, 9);
        tick();
        chk("t4_over", game_over, 1);

        // Second V during scan, board changed mid-scan
        start_new_game();
        @(negedge clock);
        board = 18'd0;
        V = 1'b1;
        tick();
        V = 1'b0;
        board = 18'h00015;
        tick();
        tick();
        V = 1'b1;
        done_cnt = 0;
        first_done = 99;
        for (int k = 3; k <= 14; k++) begin
            tick();
            V = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_done == 99) first_done = k;
            end
        end
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_lat", first_done, 8);
        chk("t5_winner", winner, 0);
        chk("t5_overrun", overrun, 1);
        chk("t5_moves", moves, 1);

        // Asynchronous reset mid-scan
        @(negedge clock);
        board = 18'd0;
        V = 1'b1;
        tick();
        V = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_moves", moves, 0);
        chk("t6_rst_player", playerID, 0);
        chk("t6_rst_overrun", overrun, 0);
        @(negedge clock);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("t6_no_done", done_cnt, 0);

        // new_game together with V: V dropped
        move(18'd0, lat);
        chk("t6_pre_moves", moves, 1);
        tick();
        new_game = 1'b1;
        V = 1'b1;
        tick();
        new_game = 1'b0;
        V = 1'b0;
        chk("t6_ng_moves", moves, 0);
        chk("t6_ng_busy", busy, 0);
        chk("t6_ng_player", playerID, 0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("t6_ng_no_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/evaluar_jugada.md
# evaluar_jugada

Post-move referee for the tic-tac-toe datapath. Sits directly downstream of the move-validation stage: consumes its move-accepted pulse and the nine 2-bit box registers, then scans the eight winning lines one per clock. Reports win, draw or continue, and owns the turn toggle and move counter that feed the next move's player ID.

## Interface
- Parameters: none; board geometry is fixed at 3x3.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- V  in  1  move-accepted pulse from validation stage; sampled only in IDLE.
- board  in  18  box k (1..9) at board[2k-1:2k-2]; 00 empty, 01 player 0, 10 player 1, 11 treated as empty.
- new_game  in  1  synchronous clear; priority over V.
- busy  out  1  high while scanning (SCAN state).
- done  out  1  one-cycle pulse when the evaluation result is valid.
- winner  out  2  code of the winning player (01/10); 00 if none.
- win_line  out  3  index of the winning line; valid when winner != 00.
- draw  out  1  board full with no winner.
- game_over  out  1  level; high after a win or draw until new_game or reset.
- playerID  out  1  player to move next; feeds the validation stage.
- moves  out  4  accepted moves this game, 0..9.
- overrun  out  1  sticky; V arrived while busy or game_over.

## Operation
- Line order, checked strictly in sequence, first match wins:
  - 0: 1,2,3
  - 1: 4,5,6
  - 2: 7,8,9
  - 3: 1,4,7
  - 4: 2,5,8
  - 5: 3,6,9
  - 6: 1,5,9
  - 7: 3,5,7
- A line matches when all three boxes are equal and are 01 or 10.
- States: IDLE, SCAN, REPORT, OVER.
- IDLE, V=1:
  - Snapshot board into an internal 18-bit register.
  - moves++ (saturate at 9).
  - idx=0.
  - Go to SCAN.
- SCAN:
  - Evaluate line idx against the snapshot, not live board.
  - Match: latch winner and win_line, go to REPORT.
  - No match, idx<7: idx++.
  - No match, idx=7: draw=(moves==9), go to REPORT.
- REPORT (one cycle):
  - done=1.
  - Win or draw: game_over=1, go to OVER.
  - Otherwise: playerID toggles, go to IDLE.
- OVER: V ignored, overrun set; results hold.
- winner, win_line and draw hold until the next snapshot, new_game or reset. They are cleared at the snapshot edge.
- new_game (any state): clear moves, playerID, winner, win_line, draw, game_over, overrun, idx. Go to IDLE. A V in the same cycle is dropped.
- V while in SCAN or REPORT: ignored, overrun set; no count, no snapshot.

## Timing
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; playerID=0; moves=0; snapshot=0.
- Edge E0 samples V. Line i is evaluated in the cycle following edge E(i).
- Win on line i: REPORT entered at E(i+1); done high for the cycle after E(i+1). Latency is i+1 cycles (1..8).
- No win: done high for the cycle after E8. Latency is 8 cycles.
- busy high from after E0 until the REPORT edge. busy=0 during the done cycle.
- playerID toggles at the edge leaving REPORT. It is stable for the next V.
- Earliest next V acceptance is the cycle after done. Back-to-back throughput is one move per 10 cycles worst case.
- reset asserted mid-SCAN: immediate return to reset values; no done pulse.

## Test plan
- Reset, then board=0, V pulse -> no match; done at E0+9 cycles; winner=00, draw=0, moves=1, playerID=1.
- Board boxes 1,2,3=01, V -> done one cycle after E1; winner=01, win_line=0, game_over=1, playerID unchanged.
- Boxes 3,5,7=10 only, V -> done after E8; winner=10, win_line=7. Then a further V -> ignored, overrun=1, moves unchanged.
- Nine V pulses with a full no-win board (01,10,01,01,10,10,10,01,01) -> ninth evaluation gives draw=1, winner=00, moves=9, game_over=1.
- V while busy (second pulse 3 cycles after the first) -> overrun=1; single done; moves incremented once. Board changed mid-scan does not affect the result.
- reset low mid-SCAN -> all outputs 0 immediately, no done. new_game asserted with V in the same cycle -> cleared, V dropped, moves=0.
